// File: rtl/bsg_dff_async_reset_en.sv
// Load-enabled register with asynchronous active-high reset.
// Define BSG_DFF_ASYNC_RESET_EN_CHECK_EN to compile in simulation-only X checks.
module bsg_dff_async_reset_en #(
   parameter int                 width_p     = 1,
   parameter logic [width_p-1:0] reset_val_p = '0
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               en_i,
   input  logic [width_p-1:0] data_i,
   output logic [width_p-1:0] data_o
);

   logic [width_p-1:0] data_d;
   logic [width_p-1:0] data_q;

   // next value: capture data_i when enabled, otherwise hold
   always_comb begin
      data_d = data_q;
      if (en_i) data_d = data_i;
   end

   // state register; reset clears without waiting for a clock edge
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) data_q <= reset_val_p;
      else         data_q <= data_d;
   end

   assign data_o = data_q;

`ifdef BSG_DFF_ASYNC_RESET_EN_CHECK_EN
   // reject a zero-width register at elaboration
   if (width_p < 1) begin : g_width_chk
      $error("bsg_dff_async_reset_en: width_p must be >= 1");
   end

   // flag unknown enable, or unknown data being captured
   always @(posedge clk_i) begin
      if (!reset_i) begin
         if ($isunknown(en_i))
            $error("bsg_dff_async_reset_en: en_i is X/Z");
         else if (en_i && $isunknown(data_i))
            $error("bsg_dff_async_reset_en: data_i is X/Z on capture");
      end
   end
`endif

endmodule

// File: tb/tb_bsg_dff_async_reset_en.sv
// Directed bench for bsg_dff_async_reset_en.
// Covers an 8-bit instance and a 600-bit packet register.
module tb_bsg_dff_async_reset_en;

   logic         clk;
   logic         rst;
   logic         en8;
   logic [7:0]   d8;
   logic [7:0]   q8;
   logic         enw;
   logic [599:0] dw;
   logic [599:0] qw;
   logic [599:0] pkt;

   int unsigned checks;
   int unsigned failures;

   bsg_dff_async_reset_en #(
      .width_p     (8),
      .reset_val_p (8'hA5)
   ) dut8 (
      .clk_i   (clk),
      .reset_i (rst),
      .en_i    (en8),
      .data_i  (d8),
      .data_o  (q8)
   );

   bsg_dff_async_reset_en #(
      .width_p (600)
   ) dutw (
      .clk_i   (clk),
      .reset_i (rst),
      .en_i    (enw),
      .data_i  (dw),
      .data_o  (qw)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [599:0] obs,
                      input logic [599:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [599:0] rand600();
      logic [599:0] v;
      v = '0;
      for (int i = 0; i < 19; i++)
         v = {v[567:0], 32'($urandom)};
      return v;
   endfunction

   initial begin
      checks   = 0;
      failures = 0;
      rst = 1'b0;
      en8 = 1'b0;
      d8  = 8'h00;
      enw = 1'b0;
      dw  = '0;

      // reset asserted between edges takes effect at once
      #2 rst = 1'b1;
      #1;
      chk("rst_async_8", 600'(q8), 600'(8'hA5));
      chk("rst_async_w", qw, '0);

      // enable ignored while reset is held
      en8 = 1'b1;
      d8  = 8'h11;
      step();
      chk("rst_hold", 600'(q8), 600'(8'hA5));

      // release: no immediate change
      en8 = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("rel_nochg", 600'(q8), 600'(8'hA5));

      // first capture, not visible before the edge
      en8 = 1'b1;
      d8  = 8'h3C;
      #1;
      chk("pre_edge", 600'(q8), 600'(8'hA5));
      step();
      chk("cap_3c", 600'(q8), 600'(8'h3C));

      // hold with data toggling
      en8 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         d8 = (i % 2 == 0) ? 8'h00 : 8'hFF;
         step();
         chk("hold_3c", 600'(q8), 600'(8'h3C));
      end

      // back-to-back enables
      en8 = 1'b1;
      d8  = 8'h01;
      #1;
      chk("b2b_pre", 600'(q8), 600'(8'h3C));
      step();
      chk("b2b_01", 600'(q8), 600'(8'h01));
      d8 = 8'h02;
      step();
      chk("b2b_02", 600'(q8), 600'(8'h02));
      d8 = 8'h03;
      step();
      chk("b2b_03", 600'(q8), 600'(8'h03));

      // reset mid-hold clears between edges
      en8 = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst", 600'(q8), 600'(8'hA5));

      // reset wins over enable on an edge
      en8 = 1'b1;
      d8  = 8'h77;
      step();
      chk("rst_wins", 600'(q8), 600'(8'hA5));
      en8 = 1'b0;
      #2 rst = 1'b0;
      step();
      chk("rel_hold", 600'(q8), 600'(8'hA5));
      en8 = 1'b1;
      step();
      chk("cap_77", 600'(q8), 600'(8'h77));
      en8 = 1'b0;

      // wide packet capture and hold
      pkt = rand600();
      enw = 1'b1;
      dw  = pkt;
      step();
      chk("w_cap", qw, pkt);
      enw = 1'b0;
      for (int i = 0; i < 20; i++) begin
         dw = rand600();
         step();
         chk("w_hold", qw, pkt);
      end

      // second wide capture, then async clear
      pkt = ~pkt;
      enw = 1'b1;
      dw  = pkt;
      step();
      chk("w_cap2", qw, pkt);
      enw = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("w_rst", qw, '0);
      chk("w_rst_8", 600'(q8), 600'(8'hA5));
      #2 rst = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
